// File: rtl/d_memory_model_pkg.sv
// Shared types for the data-memory endpoint: request opcode and FSM state encoding.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

package d_memory_model_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } memory_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_t;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/d_mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read, no reset.
module d_mem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  assign rdata = r_mem[ridx];

endmodule

// File: rtl/d_memory_model.sv
// Single-outstanding data-memory endpoint: accepts one load/store, waits LATENCY cycles,
// then pulses ack with the load data sampled at acceptance.
module d_memory_model
  import d_memory_model_pkg::*;
#(
  parameter int unsigned DATA_W  = `REG_VAL_WIDTH,
  parameter int unsigned ADDR_W  = `D_MEMORY_ADDR_WIDTH,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_req_valid,
  input  memory_op_t        memory_req_op,
  input  logic [ADDR_W-1:0] memory_req_address,
  input  logic [DATA_W-1:0] memory_req_data,
  output logic              memory_ready,
  output logic              memory_ack,
  output logic [DATA_W-1:0] memory_data_return
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  memory_op_t        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [IDX_W-1:0]  w_req_idx;
  logic [DATA_W-1:0] w_array_rdata;
  logic              w_accept;
  logic              w_we;
  logic              w_unused_addr;

  // Byte-offset bits drop out and upper bits wrap modulo DEPTH.
  assign w_req_idx     = memory_req_address[OFF_W +: IDX_W];
  assign w_unused_addr = ^memory_req_address;

  d_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .widx  (r_idx),
    .wdata (r_wdata),
    .ridx  (w_req_idx),
    .rdata (w_array_rdata)
  );

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_accept           = 1'b0;
    w_we               = 1'b0;
    memory_ready       = 1'b0;
    memory_ack         = 1'b0;
    memory_data_return = '0;
    unique case (r_state)
      StIdle: begin
        memory_ready = 1'b1;
        if (memory_req_valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_W'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? StResp : StBusy;
        end
      end
      StBusy: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        memory_ack = 1'b1;
        // Stores commit on the edge leaving RESP, so a reset here discards them.
        if (r_op == MEM_READ) begin
          memory_data_return = r_rdata;
        end else begin
          w_we = 1'b1;
        end
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= MEM_READ;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op    <= memory_req_op;
        r_idx   <= w_req_idx;
        r_wdata <= memory_req_data;
        r_rdata <= w_array_rdata;
      end
    end
  end

endmodule

// File: tb/tb_d_memory_model.sv
// Scoreboard bench: drivers push expected responses, negedge monitors pop them on each ack.
module tb_d_memory_model;
  import d_memory_model_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 64;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_ack;
  memory_op_t    a_op;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_ack;
  memory_op_t    b_op;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  d_memory_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut (
    .clk                (clk),
    .reset              (reset),
    .memory_req_valid   (a_valid),
    .memory_req_op      (a_op),
    .memory_req_address (a_addr),
    .memory_req_data    (a_wdata),
    .memory_ready       (a_ready),
    .memory_ack         (a_ack),
    .memory_data_return (a_rdata)
  );

  d_memory_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_lat1 (
    .clk                (clk),
    .reset              (reset),
    .memory_req_valid   (b_valid),
    .memory_req_op      (b_op),
    .memory_req_address (b_addr),
    .memory_req_data    (b_wdata),
    .memory_ready       (b_ready),
    .memory_ack         (b_ack),
    .memory_data_return (b_rdata)
  );

  typedef struct {
    bit          is_wr;
    int          idx;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma[DEPTH];
  logic [31:0] mb[DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          b_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired, required completion (cycle %0d)", name, cyc);
  endtask

  function automatic int word_of(input logic [AW-1:0] addr);
    return (int'(addr) / (DW / 8)) % DEPTH;
  endfunction

  // Issue one request on the LATENCY=4 instance; returns just after the accepting edge.
  task automatic req_a(input memory_op_t op, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!a_ready) begin
      n++;
      if (n > 100) begin
        fail_now("a_wait_ready");
        return;
      end
      @(negedge clk);
    end
    a_valid = 1'b1;
    a_op    = op;
    a_addr  = addr;
    a_wdata = d;
    e.is_wr = (op == MEM_WRITE);
    e.idx   = word_of(addr);
    e.data  = e.is_wr ? d : ma[e.idx];
    e.acc   = cyc;
    qa.push_back(e);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_addr  = AW'($urandom);
    a_wdata = $urandom;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        fail_now("a_drain");
        qa.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_ready"}, a_ready, 1'b1);
    check1({tag, "_ack"}, a_ack, 1'b0);
    check({tag, "_data"}, a_rdata, 32'h0);
  endtask

  logic a_ack_prev;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset) begin
      a_ack_prev <= 1'b0;
    end else begin
      if (a_ack) begin
        if (qa.size() == 0) begin
          fail_now("a_unexpected_ack");
        end else begin
          e = qa.pop_front();
          check("a_latency", 32'(cyc - e.acc), 32'(LAT_A));
          check("a_data", a_rdata, e.is_wr ? 32'h0 : e.data);
          if (e.is_wr) ma[e.idx] = e.data;
        end
      end else begin
        check("a_data_idle", a_rdata, 32'h0);
        if (qa.size() != 0 && qa[0].acc < cyc) check1("a_ready_busy", a_ready, 1'b0);
      end
      if (a_ack_prev) check1("a_ready_after_ack", a_ready, 1'b1);
      a_ack_prev <= a_ack;
    end
  end

  logic b_ack_prev;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset) begin
      b_ack_prev <= 1'b0;
    end else begin
      if (b_ack) begin
        check1("b_ack_width", b_ack_prev, 1'b0);
        b_acks = b_acks + 1;
        if (qb.size() == 0) begin
          fail_now("b_unexpected_ack");
        end else begin
          e = qb.pop_front();
          check("b_latency", 32'(cyc - e.acc), 32'(LAT_B));
          check("b_data", b_rdata, e.is_wr ? 32'h0 : e.data);
          if (e.is_wr) mb[e.idx] = e.data;
        end
      end
      b_ack_prev <= b_ack;
    end
  end

  initial begin
    int   n;
    int   k;
    int   last;
    exp_t e;
    reset   = 1'b1;
    a_valid = 1'b0;
    a_op    = MEM_READ;
    a_addr  = '0;
    a_wdata = '0;
    b_valid = 1'b0;
    b_op    = MEM_READ;
    b_addr  = '0;
    b_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_released");

    // Fill every word so later reads have a known model value.
    for (int i = 0; i < DEPTH; i++) req_a(MEM_WRITE, AW'(i * 4), $urandom);
    drain_a();

    req_a(MEM_WRITE, 16'h0040, 32'hDEAD_BEEF);
    req_a(MEM_READ, 16'h0040, '0);
    drain_a();
    check("deadbeef_model", ma[16], 32'hDEAD_BEEF);

    req_a(MEM_WRITE, 16'h0040, 32'h0000_1234);
    req_a(MEM_READ, 16'h0043, '0);
    req_a(MEM_WRITE, 16'(DEPTH * DW / 8 + 8), 32'hC0FF_EE01);
    req_a(MEM_READ, 16'h0008, '0);
    drain_a();

    // Valid pulsed while busy must be ignored.
    req_a(MEM_WRITE, 16'h0030, 32'h1111_2222);
    @(negedge clk);
    a_valid = 1'b1;
    a_op    = MEM_WRITE;
    a_addr  = 16'h0034;
    a_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    a_valid = 1'b0;
    drain_a();
    req_a(MEM_READ, 16'h0034, '0);
    req_a(MEM_READ, 16'h0030, '0);
    drain_a();

    // Reset during BUSY of a write: aborted, array untouched.
    req_a(MEM_WRITE, 16'h0010, 32'h0000_0055);
    @(negedge clk);
    #2 reset = 1'b1;
    qa.delete();
    #1 check_reset_outputs("rst_busy");
    @(negedge clk);
    #2 reset = 1'b0;
    req_a(MEM_READ, 16'h0010, '0);
    drain_a();

    // Reset while the read ack is showing.
    req_a(MEM_READ, 16'h0020, '0);
    n = 0;
    @(negedge clk);
    while (!a_ack && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!a_ack) fail_now("a_wait_ack");
    #1 reset = 1'b1;
    qa.delete();
    #1 check_reset_outputs("rst_resp");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", a_ready, 1'b1);
    req_a(MEM_WRITE, 16'h0024, 32'h7777_8888);
    req_a(MEM_READ, 16'h0024, '0);
    drain_a();

    for (int i = 0; i < 60; i++) begin
      req_a(memory_op_t'($urandom_range(0, 1)), AW'($urandom), $urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    drain_a();
    check("a_queue_empty", 32'(qa.size()), 32'h0);

    // LATENCY=1 instance with valid held high across requests.
    k    = 0;
    last = -1;
    n    = 0;
    while (k < 8 && n < 100) begin
      @(negedge clk);
      n++;
      b_valid = 1'b1;
      b_op    = (k < 4) ? MEM_WRITE : MEM_READ;
      b_addr  = AW'((k % 4) * 4);
      b_wdata = 32'hA000_0000 + 32'(k);
      if (b_ready) begin
        e.is_wr = (b_op == MEM_WRITE);
        e.idx   = word_of(b_addr);
        e.data  = e.is_wr ? b_wdata : mb[e.idx];
        e.acc   = cyc;
        qb.push_back(e);
        if (last >= 0) check("b_accept_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        k++;
      end
    end
    @(negedge clk);
    b_valid = 1'b0;
    if (k < 8) fail_now("b_accepts");
    repeat (4) @(negedge clk);
    check("b_ack_count", 32'(b_acks), 32'd8);
    check("b_queue_empty", 32'(qb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
